// File: rtl/fifo_pkg.sv
`timescale 1ns/1ps
// fifo_pkg: gray-code helpers and constants shared by the dual-clock FIFO.
package fifo_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  // Helpers work on a fixed 32-bit word; callers cast to/from their pointer width.
  localparam int PTR_FN_W = 32;

  function automatic logic [PTR_FN_W-1:0] bin2gray(input logic [PTR_FN_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_FN_W-1:0] gray2bin(input logic [PTR_FN_W-1:0] g);
    logic [PTR_FN_W-1:0] b;
    b = '0;
    b[PTR_FN_W-1] = g[PTR_FN_W-1];
    for (int i = PTR_FN_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_sync.sv
`timescale 1ns/1ps
// gray_sync: multi-flop synchroniser for a gray-coded pointer, async reset to 0.
module gray_sync #(
  parameter int WIDTH  = 9,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  // Shift the source-domain gray value through STAGES flops.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_async_flags.sv
`timescale 1ns/1ps
// fifo_async_flags: dual-clock FIFO with programmable almost-full/almost-empty,
// per-side fill counts, sticky overflow/underflow and an optional
// first-word-fall-through read port.
module fifo_async_flags
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 4,
  parameter int AEMPTY_THRESH = 4,
  parameter bit FWFT          = 1'b0
) (
  input  logic                  rst,
  input  logic                  wr_clk,
  input  logic                  rd_clk,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_count,
  output logic                  overflow,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   rd_count,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_err_sync
    $error("fifo_async_flags: SYNC_STAGES out of range 2..4");
  end
  if (AFULL_THRESH > DEPTH) begin : g_err_afull
    $error("fifo_async_flags: AFULL_THRESH exceeds DEPTH");
  end
  if (AEMPTY_THRESH >= DEPTH) begin : g_err_aempty
    $error("fifo_async_flags: AEMPTY_THRESH must be below DEPTH");
  end
  // The full compare needs two pointer MSBs plus at least one low bit.
  if (ADDR_WIDTH < 2 || ADDR_WIDTH > 30) begin : g_err_addr
    $error("fifo_async_flags: ADDR_WIDTH out of range 2..30");
  end

  // ---------------------------------------------------------------- resets
  logic [1:0] wr_rst_q;
  logic [1:0] rd_rst_q;
  logic       wr_rst;
  logic       rd_rst;

  // Write-domain reset: asserts with rst, releases on the second wr_clk edge.
  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) wr_rst_q <= 2'b11;
    else     wr_rst_q <= {wr_rst_q[0], 1'b0};
  end

  // Read-domain reset: asserts with rst, releases on the second rd_clk edge.
  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) rd_rst_q <= 2'b11;
    else     rd_rst_q <= {rd_rst_q[0], 1'b0};
  end

  assign wr_rst = wr_rst_q[1];
  assign rd_rst = rd_rst_q[1];

  // ---------------------------------------------------------------- storage
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // ---------------------------------------------------------------- write side
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] wr_gray_q, wr_gray_d;
  logic [PW-1:0] wr_count_q, wr_count_d;
  logic [PW-1:0] rs_gray, rs_bin;
  logic [PW-1:0] rd_gray_q;
  logic          full_q, full_d;
  logic          afull_q;
  logic          overflow_q;
  logic          wr_fire;

  gray_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_sync_r2w (
    .clk_i (wr_clk),
    .rst_i (wr_rst),
    .d_i   (rd_gray_q),
    .q_o   (rs_gray)
  );

  assign wr_fire    = wr_en & ~full_q;
  assign wr_ptr_d   = wr_ptr_q + PW'(wr_fire);
  assign wr_gray_d  = PW'(bin2gray(PTR_FN_W'(wr_ptr_d)));
  assign rs_bin     = PW'(gray2bin(PTR_FN_W'(rs_gray)));
  // The synced read pointer lags, so this count can only over-state occupancy.
  assign wr_count_d = wr_ptr_d - rs_bin;
  // Full when the write pointer is one lap ahead: top two gray bits inverted.
  assign full_d     = (wr_gray_d == {~rs_gray[PW-1:PW-2], rs_gray[PW-3:0]});

  // Storage has no reset so it can map onto block RAM.
  always_ff @(posedge wr_clk) begin
    if (wr_fire) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= din;
  end

  // Write pointer, flags and count, all computed from next-pointer values.
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      wr_ptr_q   <= '0;
      wr_gray_q  <= '0;
      wr_count_q <= '0;
      full_q     <= 1'b0;
      afull_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      wr_gray_q  <= wr_gray_d;
      wr_count_q <= wr_count_d;
      full_q     <= full_d;
      afull_q    <= (wr_count_d >= PW'(AFULL_THRESH));
      overflow_q <= overflow_q | (wr_en & full_q);
    end
  end

  assign full        = full_q;
  assign almost_full = afull_q;
  assign wr_count    = wr_count_q;
  assign overflow    = overflow_q;

  // ---------------------------------------------------------------- read side
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         rd_gray_d;
  logic [PW-1:0]         rd_count_q, rd_count_d;
  logic [PW-1:0]         ws_gray, ws_bin;
  logic                  ram_empty_q;
  logic                  aempty_q;
  logic                  underflow_q;
  logic                  rd_adv;
  logic                  uf_hit;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  valid_q;

  gray_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_sync_w2r (
    .clk_i (rd_clk),
    .rst_i (rd_rst),
    .d_i   (wr_gray_q),
    .q_o   (ws_gray)
  );

  assign rd_ptr_d   = rd_ptr_q + PW'(rd_adv);
  assign rd_gray_d  = PW'(bin2gray(PTR_FN_W'(rd_ptr_d)));
  assign ws_bin     = PW'(gray2bin(PTR_FN_W'(ws_gray)));
  // The synced write pointer lags, so this count can only under-state occupancy.
  assign rd_count_d = ws_bin - rd_ptr_d;

  if (FWFT) begin : g_fwft
    logic consume;
    logic load;

    assign consume = rd_en & valid_q;
    // Refill the output register when it is free or being consumed this cycle.
    assign load    = ~ram_empty_q & (~valid_q | consume);
    assign rd_adv  = load;
    assign uf_hit  = rd_en & ~valid_q;

    // One-entry prefetch register in front of the RAM.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
        dout_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= load | (valid_q & ~consume);
        if (load) dout_q <= mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
      end
    end

    assign empty = ~valid_q;
  end else begin : g_std
    assign rd_adv = rd_en & ~ram_empty_q;
    assign uf_hit = rd_en & ram_empty_q;

    // Registered RAM read; dout holds its last word between reads.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
        dout_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_adv;
        if (rd_adv) dout_q <= mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
      end
    end

    assign empty = ram_empty_q;
  end

  // Read pointer, RAM-empty flag and count, all computed from next-pointer values.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      rd_ptr_q    <= '0;
      rd_gray_q   <= '0;
      rd_count_q  <= '0;
      ram_empty_q <= 1'b1;
      aempty_q    <= 1'b1;
      underflow_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      rd_gray_q   <= rd_gray_d;
      rd_count_q  <= rd_count_d;
      ram_empty_q <= (rd_gray_d == ws_gray);
      aempty_q    <= (rd_count_d <= PW'(AEMPTY_THRESH));
      underflow_q <= underflow_q | uf_hit;
    end
  end

  assign dout         = dout_q;
  assign valid        = valid_q;
  assign almost_empty = aempty_q;
  assign rd_count     = rd_count_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_async_flags.sv
`timescale 1ns/1ps
// Bench for fifo_async_flags: DEPTH=16, thresholds 12/4, two-stage sync,
// one standard-read instance and one FWFT instance.
module tb_fifo_async_flags;

  localparam int DW = 16;
  localparam int AW = 4;

  realtime wr_half = 5.0;
  realtime rd_half = 13.5;

  logic rst    = 1'b0;
  logic wr_clk = 1'b0;
  logic rd_clk = 1'b0;

  always #(wr_half) wr_clk = ~wr_clk;
  always #(rd_half) rd_clk = ~rd_clk;

  logic          wr_en = 1'b0, rd_en = 1'b0;
  logic [DW-1:0] din = '0;
  logic          full, almost_full, overflow, valid, empty, almost_empty, underflow;
  logic [AW:0]   wr_count, rd_count;
  logic [DW-1:0] dout;

  logic          fw_wr_en = 1'b0, fw_rd_en = 1'b0;
  logic [DW-1:0] fw_din = '0;
  logic          fw_full, fw_afull, fw_ovf, fw_valid, fw_empty, fw_aempty, fw_udf;
  logic [AW:0]   fw_wr_count, fw_rd_count;
  logic [DW-1:0] fw_dout;

  fifo_async_flags #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SYNC_STAGES(2),
                     .AFULL_THRESH(12), .AEMPTY_THRESH(4), .FWFT(1'b0)) dut (
    .rst(rst), .wr_clk(wr_clk), .rd_clk(rd_clk),
    .wr_en(wr_en), .din(din), .full(full), .almost_full(almost_full),
    .wr_count(wr_count), .overflow(overflow),
    .rd_en(rd_en), .dout(dout), .valid(valid), .empty(empty),
    .almost_empty(almost_empty), .rd_count(rd_count), .underflow(underflow)
  );

  fifo_async_flags #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SYNC_STAGES(2),
                     .AFULL_THRESH(12), .AEMPTY_THRESH(4), .FWFT(1'b1)) dut_fw (
    .rst(rst), .wr_clk(wr_clk), .rd_clk(rd_clk),
    .wr_en(fw_wr_en), .din(fw_din), .full(fw_full), .almost_full(fw_afull),
    .wr_count(fw_wr_count), .overflow(fw_ovf),
    .rd_en(fw_rd_en), .dout(fw_dout), .valid(fw_valid), .empty(fw_empty),
    .almost_empty(fw_aempty), .rd_count(fw_rd_count), .underflow(fw_udf)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    wr_en = 1'b0; rd_en = 1'b0; fw_wr_en = 1'b0; fw_rd_en = 1'b0;
    rst = 1'b1;
    #40;
    rst = 1'b0;
    repeat (4) @(negedge rd_clk);
    repeat (4) @(negedge wr_clk);
  endtask

  logic [DW-1:0] sb[$];
  logic [31:0]   exp_w;
  int            got, wmax, rmax, edges;
  bit            seen;
  localparam int N5 = 64;
  localparam int N4 = 2000;

  initial begin
    // ------------------------------------------------ reset values
    #2 rst = 1'b1;
    #40;
    chk("rst_full", full, 0);           chk("rst_afull", almost_full, 0);
    chk("rst_wrcnt", wr_count, 0);      chk("rst_ovf", overflow, 0);
    chk("rst_empty", empty, 1);         chk("rst_aempty", almost_empty, 1);
    chk("rst_rdcnt", rd_count, 0);      chk("rst_udf", underflow, 0);
    chk("rst_valid", valid, 0);         chk("rst_dout", dout, 0);
    chk("rst_fw_full", fw_full, 0);     chk("rst_fw_afull", fw_afull, 0);
    chk("rst_fw_wrcnt", fw_wr_count, 0); chk("rst_fw_ovf", fw_ovf, 0);
    chk("rst_fw_empty", fw_empty, 1);   chk("rst_fw_aempty", fw_aempty, 1);
    chk("rst_fw_rdcnt", fw_rd_count, 0); chk("rst_fw_udf", fw_udf, 0);
    chk("rst_fw_valid", fw_valid, 0);   chk("rst_fw_dout", fw_dout, 0);
    rst = 1'b0;
    repeat (4) @(negedge rd_clk);
    repeat (4) @(negedge wr_clk);

    // ------------------------------------------------ 1: fill 16, overflow
    for (int i = 1; i <= 16; i++) begin
      @(negedge wr_clk);
      chk("fill_wrcnt", wr_count, i - 1);
      chk("fill_afull", almost_full, (i - 1) >= 12);
      chk("fill_full", full, 0);
      wr_en = 1'b1; din = DW'(i);
    end
    @(negedge wr_clk);
    wr_en = 1'b0;
    chk("full_after16", full, 1);
    chk("wrcnt_16", wr_count, 16);
    chk("afull_16", almost_full, 1);
    chk("no_ovf_yet", overflow, 0);
    wr_en = 1'b1; din = 16'h0011;
    @(negedge wr_clk);
    wr_en = 1'b0;
    chk("ovf_set", overflow, 1);
    chk("wrcnt_drop", wr_count, 16);
    chk("full_hold", full, 1);

    // ------------------------------------------------ 2: drain
    repeat (5) @(negedge rd_clk);
    chk("drain_rdcnt", rd_count, 16);
    chk("drain_empty0", empty, 0);
    chk("drain_aempty0", almost_empty, 0);
    rd_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge rd_clk);
      if (i == 16) rd_en = 1'b0;
      chk("drain_valid", valid, 1);
      chk("drain_data", dout, i);
      chk("drain_rdcnt_i", rd_count, 16 - i);
      chk("drain_aempty_i", almost_empty, (16 - i) <= 4);
    end
    chk("empty_after", empty, 1);
    chk("udf_clear", underflow, 0);
    rd_en = 1'b1;
    @(negedge rd_clk);
    rd_en = 1'b0;
    chk("udf_set", underflow, 1);
    chk("udf_valid0", valid, 0);
    chk("dout_hold", dout, 16'h0010);
    repeat (6) @(negedge wr_clk);
    chk("full_clear", full, 0);
    chk("wrcnt_0", wr_count, 0);
    chk("ovf_sticky", overflow, 1);

    // ------------------------------------------------ 3: FWFT single word
    @(negedge wr_clk);
    fw_wr_en = 1'b1; fw_din = 16'hBEEF;
    @(posedge wr_clk);
    #1 fw_wr_en = 1'b0;
    seen = 1'b0; edges = 0;
    while (!seen && edges < 8) begin
      @(posedge rd_clk);
      #1;
      edges++;
      if (fw_valid) seen = 1'b1;
    end
    chk("fw_valid_seen", seen, 1);
    chk("fw_latency_le4", edges <= 4, 1);
    chk("fw_dout", fw_dout, 16'hBEEF);
    chk("fw_empty0", fw_empty, 0);
    @(negedge rd_clk);
    fw_rd_en = 1'b1;
    @(negedge rd_clk);
    fw_rd_en = 1'b0;
    chk("fw_valid0", fw_valid, 0);
    chk("fw_empty1", fw_empty, 1);
    chk("fw_udf0", fw_udf, 0);
    fw_rd_en = 1'b1;
    @(negedge rd_clk);
    fw_rd_en = 1'b0;
    chk("fw_udf1", fw_udf, 1);

    // ------------------------------------------------ 5: streaming over wraps
    do_reset();
    got = 0;
    fork
      begin
        int n = 0;
        int cyc = 0;
        while (n < N5 && cyc < 5000) begin
          @(negedge wr_clk);
          cyc++;
          if (!full) begin wr_en = 1'b1; din = DW'(16'h0100 + n); n++; end
          else wr_en = 1'b0;
        end
        @(negedge wr_clk);
        wr_en = 1'b0;
      end
      begin
        int cyc = 0;
        repeat (40) @(negedge rd_clk);
        while (got < N5 && cyc < 3000) begin
          @(negedge rd_clk);
          cyc++;
          if (valid) begin
            chk("stream_data", dout, 16'h0100 + got);
            got++;
          end
          rd_en = ~empty;
        end
        rd_en = 1'b0;
      end
    join
    chk("stream_count", got, N5);
    chk("stream_ovf", overflow, 0);
    chk("stream_udf", underflow, 0);
    repeat (5) @(negedge rd_clk);
    chk("stream_empty", empty, 1);
    chk("stream_full", full, 0);

    // ------------------------------------------------ 4: random, clocks swapped
    do_reset();
    wr_half = 13.5; rd_half = 5.0;
    repeat (4) @(negedge wr_clk);
    got = 0; wmax = 0; rmax = 0;
    fork
      begin
        int n = 0;
        int cyc = 0;
        while (n < N4 && cyc < 20000) begin
          @(negedge wr_clk);
          cyc++;
          if (int'(wr_count) > wmax) wmax = int'(wr_count);
          if ($urandom_range(1) == 1 && !full) begin
            wr_en = 1'b1; din = DW'($urandom); sb.push_back(din); n++;
          end else wr_en = 1'b0;
        end
        @(negedge wr_clk);
        wr_en = 1'b0;
      end
      begin
        int cyc = 0;
        while (got < N4 && cyc < 60000) begin
          @(negedge rd_clk);
          cyc++;
          if (int'(rd_count) > rmax) rmax = int'(rd_count);
          if (valid) begin
            exp_w = (sb.size() > 0) ? 32'(sb.pop_front()) : 32'hDEAD0000;
            chk("rand_data", dout, exp_w);
            got++;
          end
          rd_en = ($urandom_range(1) == 1) && !empty;
        end
        rd_en = 1'b0;
      end
    join
    chk("rand_count", got, N4);
    chk("rand_sb_left", sb.size(), 0);
    chk("rand_ovf", overflow, 0);
    chk("rand_udf", underflow, 0);
    chk("rand_wmax_le16", wmax <= 16, 1);
    chk("rand_rmax_le16", rmax <= 16, 1);
    wr_half = 5.0; rd_half = 13.5;

    // ------------------------------------------------ 6: reset at 8 entries
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge wr_clk);
      wr_en = 1'b1; din = DW'(16'h0A00 + i);
    end
    @(negedge wr_clk);
    wr_en = 1'b0;
    repeat (5) @(negedge rd_clk);
    chk("pre_rst_rdcnt", rd_count, 8);
    chk("pre_rst_wrcnt", wr_count, 8);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_full", full, 0);         chk("mid_rst_afull", almost_full, 0);
    chk("mid_rst_wrcnt", wr_count, 0);    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_empty", empty, 1);       chk("mid_rst_aempty", almost_empty, 1);
    chk("mid_rst_rdcnt", rd_count, 0);    chk("mid_rst_udf", underflow, 0);
    chk("mid_rst_valid", valid, 0);       chk("mid_rst_dout", dout, 0);
    #30 rst = 1'b0;
    repeat (4) @(negedge rd_clk);
    repeat (4) @(negedge wr_clk);
    chk("post_rst_empty", empty, 1);
    wr_en = 1'b1; din = 16'h1234;
    @(negedge wr_clk);
    wr_en = 1'b0;
    edges = 0;
    while (empty && edges < 10) begin
      @(negedge rd_clk);
      edges++;
    end
    chk("post_rst_ne", empty, 0);
    chk("post_rst_rdcnt", rd_count, 1);
    rd_en = 1'b1;
    @(negedge rd_clk);
    rd_en = 1'b0;
    chk("post_rst_valid", valid, 1);
    chk("post_rst_data", dout, 16'h1234);
    chk("post_rst_empty2", empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
